// File: rtl/fp_add_norm_pipe.sv
// Two-stage post-normaliser for a floating-point adder: S1 normalises the raw
// signed-magnitude sum, S2 rounds (RNE/RTZ), handles range limits and packs.
module fp_add_norm_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W-1:0]         in_exp,
  input  logic [MAN_W+4:0]         in_man,
  input  logic                     in_rnd,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic                     out_overflow,
  output logic                     out_underflow,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int EW   = EXP_W + 2;
  localparam int LZ_W = $clog2(MAN_W + 4);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  // S1 registers
  logic                   s1_valid;
  logic                   s1_sign;
  logic signed [EW-1:0]   s1_exp;
  logic [MAN_W+3:0]       s1_man;
  logic                   s1_rnd;
  logic [TAG_W-1:0]       s1_tag;
  logic                   s1_special;
  logic                   s1_zero;

  logic s2_valid;
  logic s2_load;

  assign s2_load   = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s2_load;
  assign out_valid = s2_valid;

  // ---------------- S1: normalise ----------------
  logic [MAN_W+3:0]     body;
  logic [LZ_W-1:0]      lz;
  logic [MAN_W+3:0]     norm_man;
  logic signed [EW-1:0] norm_exp;

  assign body = in_man[MAN_W+3:0];

  // Scanning upward leaves lz set by the highest one bit.
  always_comb begin
    lz = LZ_W'(MAN_W + 3);
    for (int i = 0; i <= MAN_W + 3; i++) begin
      if (body[i]) lz = LZ_W'(MAN_W + 3 - i);
    end
  end

  always_comb begin
    if (in_man[MAN_W+4]) begin
      norm_man = {in_man[MAN_W+4:2], in_man[1] | in_man[0]};
      norm_exp = $signed({2'b00, in_exp}) + EW'(1);
    end else begin
      norm_man = body << lz;
      norm_exp = $signed({2'b00, in_exp}) - $signed(EW'(lz));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_man     <= '0;
      s1_rnd     <= 1'b0;
      s1_tag     <= '0;
      s1_special <= 1'b0;
      s1_zero    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_exp     <= norm_exp;
        s1_man     <= norm_man;
        s1_rnd     <= in_rnd;
        s1_tag     <= in_tag;
        s1_special <= &in_exp;
        s1_zero    <= ~|in_man;
      end
    end
  end

  // ---------------- S2: round and pack ----------------
  logic                   rnd_inc;
  logic [MAN_W:0]         frac_sum;
  logic signed [EW-1:0]   exp_r;
  logic [EXP_W+MAN_W:0]   pk_result;
  logic                   pk_ovf;
  logic                   pk_unf;

  assign rnd_inc  = !s1_rnd & s1_man[2] & (s1_man[1] | s1_man[0] | s1_man[3]);
  assign frac_sum = {1'b0, s1_man[MAN_W+2:3]} + (MAN_W+1)'(rnd_inc);
  // A carry out of the fraction leaves it all-zero, so only the exponent moves.
  assign exp_r    = s1_exp + $signed(EW'(frac_sum[MAN_W]));

  always_comb begin
    pk_result = {s1_sign, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    pk_ovf    = 1'b0;
    pk_unf    = 1'b0;
    if (s1_special) begin
      pk_result = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_zero) begin
      pk_result = '0;
    end else if (exp_r <= EZERO) begin
      pk_result = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
      pk_unf    = 1'b1;
    end else if (exp_r >= EMAX) begin
      pk_ovf = 1'b1;
      if (s1_rnd) pk_result = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else        pk_result = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_tag       <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= pk_result;
        out_overflow  <= pk_ovf;
        out_underflow <= pk_unf;
        out_tag       <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_norm_pipe.sv
// Bench for fp_add_norm_pipe: value-level reference model, scoreboard compare
// at every output handshake, and directed latency/backpressure/reset scenarios.
module tb_fp_add_norm_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int TAG_W = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   in_sign = 1'b0;
  logic [EXP_W-1:0]       in_exp = '0;
  logic [MAN_W+4:0]       in_man = '0;
  logic                   in_rnd = 1'b0;
  logic [TAG_W-1:0]       in_tag = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [EXP_W+MAN_W:0]   out_result;
  logic                   out_overflow;
  logic                   out_underflow;
  logic [TAG_W-1:0]       out_tag;

  fp_add_norm_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_rnd(in_rnd), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  int n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: treat in_man as an integer, keep the top 11 significant bits,
  // round on the value of the discarded remainder, then clamp the range.
  // Returns {overflow, underflow, result}.
  function automatic logic [17:0] model(input logic sign, input logic [4:0] ex,
                                        input logic [14:0] man, input logic rnd);
    int msb, e, sh, kept, rem, half, m;
    if (ex == 5'd31) return {2'b00, sign, 5'h1F, 10'h000};
    if (man == 15'd0) return 18'd0;
    m = int'(man);
    msb = 0;
    for (int i = 0; i < 15; i++) if (man[i]) msb = i;
    e  = int'(ex) + msb - 13;
    sh = msb - 10;
    if (sh > 0) begin
      kept = m >> sh;
      rem  = m & ((1 << sh) - 1);
      half = 1 << (sh - 1);
    end else begin
      kept = m << (-sh);
      rem  = 0;
      half = 1;
    end
    if (!rnd && (rem > half || (rem == half && (kept % 2) == 1))) kept++;
    if (kept == 2048) begin
      kept = 1024;
      e++;
    end
    if (e <= 0)  return {2'b01, sign, 15'h0000};
    if (e >= 31) return rnd ? {2'b10, sign, 5'h1E, 10'h3FF} : {2'b10, sign, 5'h1F, 10'h000};
    return {2'b00, sign, 5'(e), 10'(kept)};
  endfunction

  // Scoreboard and compare process, all sampling on the falling edge.
  logic [21:0] exp_q[$];
  logic        hold_act = 1'b0;
  logic [21:0] hold_val;

  always @(negedge clk) begin
    logic [21:0] e_item;
    if (rst) begin
      exp_q.delete();
      hold_act = 1'b0;
    end else begin
      if (hold_act) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_stable", {10'd0, out_tag, out_overflow, out_underflow, out_result}, {10'd0, hold_val});
      end
      hold_act = out_valid && !out_ready;
      hold_val = {out_tag, out_overflow, out_underflow, out_result};
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got tag %0d result %h, expected no beat", out_tag, out_result);
        end else begin
          e_item = exp_q.pop_front();
          chk("beat", {10'd0, out_tag, out_overflow, out_underflow, out_result}, {10'd0, e_item});
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        exp_q.push_back({in_tag, model(in_sign, in_exp, in_man, in_rnd)});
      end
    end
  end

  task automatic send(input logic s, input logic [4:0] e, input logic [14:0] m,
                      input logic r, input logic [3:0] t);
    int waited;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_man = m; in_rnd = r; in_tag = t;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic sign; logic [4:0] ex; logic [14:0] man; logic rnd; logic [17:0] req;
  } vec_t;

  vec_t vecs[14] = '{
    '{1'b0, 5'd15, 15'b10_0000000000_000, 1'b0, {2'b00, 16'h4000}},
    '{1'b0, 5'd15, 15'b00_0000000001_000, 1'b0, {2'b00, 16'h1400}},
    '{1'b0, 5'd15, 15'b01_1111111111_100, 1'b0, {2'b00, 16'h4000}},
    '{1'b0, 5'd15, 15'b01_1111111111_100, 1'b1, {2'b00, 16'h3FFF}},
    '{1'b0, 5'd30, 15'b10_0000000000_000, 1'b0, {2'b10, 16'h7C00}},
    '{1'b0, 5'd30, 15'b10_0000000000_000, 1'b1, {2'b10, 16'h7BFF}},
    '{1'b0, 5'd3,  15'b00_0001000000_000, 1'b0, {2'b01, 16'h0000}},
    '{1'b1, 5'd20, 15'b00_0000000000_000, 1'b0, {2'b00, 16'h0000}},
    '{1'b1, 5'd31, 15'b01_0000000000_000, 1'b0, {2'b00, 16'hFC00}},
    '{1'b0, 5'd15, 15'b01_0000000000_100, 1'b0, {2'b00, 16'h3C00}},
    '{1'b0, 5'd15, 15'b01_0000000001_100, 1'b0, {2'b00, 16'h3C02}},
    '{1'b0, 5'd15, 15'b10_0000000001_000, 1'b0, {2'b00, 16'h4000}},
    '{1'b0, 5'd15, 15'b10_0000000001_001, 1'b0, {2'b00, 16'h4001}},
    '{1'b1, 5'd10, 15'b01_1000000000_000, 1'b0, {2'b00, 16'hAA00}}
  };

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    chk("rst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    chk("rst_tag", {28'd0, out_tag}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Pin the reference model to hand-computed results
    foreach (vecs[i]) begin
      chk($sformatf("model_vec%0d", i),
          {14'd0, model(vecs[i].sign, vecs[i].ex, vecs[i].man, vecs[i].rnd)}, {14'd0, vecs[i].req});
    end

    // Latency: accepted on one edge, visible after the next
    @(posedge clk); #1;
    send(vecs[0].sign, vecs[0].ex, vecs[0].man, vecs[0].rnd, 4'd0);
    idle();
    chk("lat_s1_only", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_result", {16'd0, out_result}, 32'h4000);
    repeat (3) @(posedge clk); #1;

    // Directed vectors, one at a time, then back to back
    foreach (vecs[i]) begin
      send(vecs[i].sign, vecs[i].ex, vecs[i].man, vecs[i].rnd, 4'(i));
      idle();
      repeat (3) @(posedge clk); #1;
    end
    foreach (vecs[i]) send(vecs[i].sign, vecs[i].ex, vecs[i].man, vecs[i].rnd, 4'(i + 1));
    idle();
    repeat (4) @(posedge clk); #1;

    // Backpressure: output stalled for 4 cycles while 5 beats are offered
    out_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int t = 1; t <= 5; t++) send(1'b0, 5'd15, 15'(16'h2000 + t * 8), 1'b0, 4'(t));
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_accepted", n_acc - acc0, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("bp_all_out", {31'd0, exp_q.size() == 0}, 32'd1);

    // Randomised stream with random output stalls
    fork
      begin
        for (int k = 0; k < 150; k++)
          send(1'($urandom), 5'($urandom_range(0, 31)), 15'($urandom), 1'($urandom), 4'(k));
        idle();
      end
      begin
        repeat (400) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("stream_drained", exp_q.size(), 32'd0);
    chk("no_loss", n_out, n_acc);

    // Reset with both stages full
    out_ready = 1'b0;
    send(1'b0, 5'd15, 15'h4000, 1'b0, 4'd7);
    send(1'b0, 5'd16, 15'h4000, 1'b0, 4'd8);
    idle();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_result", {16'd0, out_result}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    send(vecs[13].sign, vecs[13].ex, vecs[13].man, vecs[13].rnd, 4'd9);
    idle();
    repeat (3) @(posedge clk); #1;
    chk("final_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
